// File: rtl/key_debouncer_pkg.sv
// Shared types and reset constants for the key_debouncer channels.
package key_debouncer_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_e;

  localparam logic SYNC_RST  = 1'b1;  // pin idles high (released)
  localparam logic LEVEL_RST = 1'b0;

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchroniser, stable-sample debounce FSM and strobes.
// Auto-repeat on the press strobe is built only with KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  chan_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, r_press, r_release;
  logic             w_pressed, w_mismatch, w_accept, w_repeat;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) r_sync <= {2{SYNC_RST}};
    else         r_sync <= {r_sync[0], i_key_n};

  assign w_pressed  = ~r_sync[1];
  assign w_mismatch = w_pressed ^ r_level;
  assign w_accept   = (r_state == ST_PENDING) && w_mismatch && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_STABLE:
        if (w_mismatch) begin
          w_state_nxt = ST_PENDING;
          w_cnt_nxt   = CNT_W'(1);
        end
      ST_PENDING:
        if (!w_mismatch || w_accept) w_state_nxt = ST_STABLE;
        else                         w_cnt_nxt   = r_cnt + 1'b1;
    endcase
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt, w_rpt_last;
  logic             r_rpt_first;

  // r_rpt counts cycles since the last press strobe; the first gap is longer
  assign w_rpt_last = r_rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  assign w_repeat   = r_level && !w_accept && (r_rpt == w_rpt_last);

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      r_rpt       <= '0;
      r_rpt_first <= 1'b1;
    end else if (!r_level || w_accept || w_repeat) begin
      r_rpt       <= '0;
      r_rpt_first <= !r_level || w_accept;
    end else begin
      r_rpt       <= r_rpt + 1'b1;
    end
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_level   <= LEVEL_RST;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= r_level ^ w_accept;
      r_press   <= (w_accept & ~r_level) | w_repeat;
      r_release <= w_accept & r_level;
    end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS active-low pushbuttons into level plus press/release strobes.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add auto-repeat on KEY_PRESS.
module key_debouncer #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] KEY_LEVEL,
  output logic [NUM_KEYS-1:0] KEY_PRESS,
  output logic [NUM_KEYS-1:0] KEY_RELEASE
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .gclk      (CLOCK_50),
      .grst_n    (RESET_N),
      .i_key_n   (KEY[k]),
      .o_level   (KEY_LEVEL[k]),
      .o_press   (KEY_PRESS[k]),
      .o_release (KEY_RELEASE[k])
    );
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Conditions the DE-board pushbuttons (active-low KEY[]) into clean, registered control signals for user logic such as LED pattern generators driving LEDR. The block is the input-side counterpart of the LED drivers. Per key, it does the following:
- Synchronises the raw pin to CLOCK_50.
- Rejects bounce with a stable-sample counter.
- Presents a debounced active-high level plus one-cycle press and release strobes.

## Interface
- NUM_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable clock cycles required to accept a change (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000: cycles from accepted press to first auto-repeat strobe (autorepeat builds only).
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat strobes (autorepeat builds only).
- CLOCK_50  input  1  system clock, rising-edge.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY  input  NUM_KEYS  raw pushbutton pins, active-low (0 = pressed), asynchronous to CLOCK_50.
- KEY_LEVEL  output  NUM_KEYS  debounced state, 1 = pressed.
- KEY_PRESS  output  NUM_KEYS  one-cycle strobe on accepted press (and on auto-repeat when built in).
- KEY_RELEASE  output  NUM_KEYS  one-cycle strobe on accepted release.

## Operation
- All channels are identical and fully independent; no cross-channel interaction.
- Synchroniser:
  - Two flops per key; both reset to 1 (released).
  - Internally inverted to active-high `pressed_sync`.
- Per-channel FSM:
  - STABLE: `pressed_sync == KEY_LEVEL`; counter held at 0.
  - PENDING: `pressed_sync != KEY_LEVEL`; counter increments once per cycle.
- Transitions:
  - STABLE→PENDING on the first cycle of mismatch; counter goes 0→1.
  - PENDING→STABLE (reject) on any cycle with a match; counter cleared; no output change.
  - PENDING→STABLE (accept) at the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists. At that edge:
    - KEY_LEVEL toggles.
    - The counter clears.
    - KEY_PRESS (0→1 transition) or KEY_RELEASE (1→0 transition) is high for exactly the following cycle.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps: it clears on accept or reject before it can reach DEBOUNCE_CYCLES.
- KEY_PRESS and KEY_RELEASE of one channel are never high in the same cycle.
- Reset values: KEY_LEVEL = 0, KEY_PRESS = 0, KEY_RELEASE = 0, all counters 0, FSM in STABLE.
- Reset is asserted asynchronously and released synchronously into STABLE. A key held through reset release is accepted as a new press after the normal debounce latency.

## Timing
- Press latency: KEY_LEVEL rises on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples KEY low as edge 1. Release latency is identical.
- Strobes are registered and high for exactly one cycle, coincident with the first cycle of the new KEY_LEVEL value.
- Minimum accepted pulse width on the pin is DEBOUNCE_CYCLES cycles. Anything shorter produces no output activity.
- Reset mid-PENDING abandons the pending change.

## Configuration
- `KEY_DEBOUNCER_AUTOREPEAT_EN` defined:
  - A per-channel repeat counter starts at the accepted press.
  - KEY_PRESS pulses again REPEAT_DELAY cycles after the initial strobe, then every REPEAT_PERIOD cycles while KEY_LEVEL stays 1.
  - The repeat counter clears on release acceptance and on reset.
  - A release and a repeat due in the same cycle yield KEY_RELEASE only.
- Macro undefined:
  - No repeat logic is synthesised.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.
  - KEY_PRESS fires exactly once per accepted press.

## Structure
- Shared package `key_debouncer_pkg` holds:
  - The channel state typedef (STABLE, PENDING).
  - The reset-value constants for the synchroniser (1) and the level (0).
- Sub-module `key_debounce_channel`:
  - Contains one synchroniser, FSM, counter and the optional repeat logic.
  - The top is a generate loop of NUM_KEYS instances.

## Test plan
- DEBOUNCE_CYCLES=4, KEY[0] held low continuously from reset release → KEY_LEVEL[0] rises on edge 6; KEY_PRESS[0] high for exactly 1 cycle; other channels stay 0.
- DEBOUNCE_CYCLES=4, KEY[1] bounces low 3 cycles / high 1 / low 2 / high → no KEY_LEVEL, KEY_PRESS or KEY_RELEASE activity.
- DEBOUNCE_CYCLES=4, KEY[2] pressed then released after 20 cycles → KEY_LEVEL[2] high for 20 cycles; KEY_RELEASE[2] strobes once, 6 edges after the release sample.
- KEY[0] and KEY[3] pressed on the same edge → both levels and both press strobes assert in the same cycle.
- RESET_N asserted mid-PENDING (counter = 2) → all outputs 0 immediately; after release with KEY still low, the press is accepted 6 edges later.
- Autorepeat build, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, key held 30 cycles → KEY_PRESS at accept, +10, +15, +20, +25; a single KEY_RELEASE after release.
